// File: rtl/modulo_cursor_coluna.sv
// ---------------------------------------------------------------------------
// modulo_cursor_coluna
//   Upstream stage of the column-coordinate encoder. Conditions the raw,
//   active-low board push-buttons (2-FF synchroniser + debouncer each),
//   detects press edges and moves a wrap-around cursor column index that
//   feeds the encoder directly. A confirm press emits a one-cycle strobe;
//   lock freezes the cursor while the game FSM is busy.
//
// Optional feature macro: AUTO_REPEAT_EN
//   defined   : a held left/right button steps again every REPEAT_CYCLES
//   undefined : exactly one step per press, no repeat logic
//
// Parameters
//   N_COLS           selectable columns (2..8), mdc in 0..N_COLS-1
//   DEBOUNCE_CYCLES  consecutive stable samples to accept a level (>=2)
//   REPEAT_CYCLES    auto-repeat period (AUTO_REPEAT_EN builds only)
//
// Ports
//   clk          system clock
//   rst_n        asynchronous reset, active-low (synchronous release)
//   btn_left_n   raw left button, active-low, asynchronous
//   btn_right_n  raw right button, active-low, asynchronous
//   btn_ok_n     raw confirm button, active-low, asynchronous
//   lock         1 = discard all button events
//   mdc          current cursor column (binary)
//   col_sel      one-hot of mdc
//   col_valid    one-cycle confirm strobe, mdc holds the chosen column
// ---------------------------------------------------------------------------
module modulo_cursor_coluna #(
   parameter int N_COLS          = 5,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int REPEAT_CYCLES   = 12500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_left_n,
   input  logic       btn_right_n,
   input  logic       btn_ok_n,
   input  logic       lock,
   output logic [2:0] mdc,
   output logic [7:0] col_sel,
   output logic       col_valid
);

   localparam int          CW   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [2:0]  LAST = 3'(N_COLS - 1);

   // Button lanes: 0 = left, 1 = right, 2 = ok
   localparam int BL = 0;
   localparam int BR = 1;
   localparam int BK = 2;

   logic [2:0] w_raw;
   logic [2:0] r_sync1;
   logic [2:0] r_sync2;
   logic [1:0] r_live;
   logic [2:0] r_arm;
   logic [2:0] w_deb;
   logic [2:0] r_deb_q;
   logic [2:0] w_press;
   logic [1:0] w_rep;

   logic [2:0] r_mdc;
   logic [7:0] r_col_sel;
   logic       r_valid;
   logic [2:0] w_mdc_nxt;
   logic       w_valid_nxt;
   logic       w_ok;
   logic       w_step_l;
   logic       w_step_r;

   assign w_raw = {btn_ok_n, btn_right_n, btn_left_n};

   // Synchroniser. r_live marks when r_sync2 carries a real sample rather
   // than its reset value. A lane is armed only after it has been seen
   // released, so a button held across reset release cannot produce a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
         r_live  <= '0;
         r_arm   <= '0;
         r_deb_q <= '1;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_live  <= {r_live[0], 1'b1};
         r_arm   <= r_arm | ({3{r_live[1]}} & r_sync2);
         r_deb_q <= w_deb;
      end
   end

   for (genvar g = 0; g < 3; g++) begin : g_deb
      logic [CW-1:0] r_cnt;
      logic          r_lvl;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt <= '0;
            r_lvl <= 1'b1;
         end else if (r_sync2[g] == r_lvl) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_lvl <= r_sync2[g];
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end

      assign w_deb[g] = r_lvl;
   end

   // Press edge: debounced level fell on the previous edge.
   assign w_press = r_deb_q & ~w_deb & r_arm;

`ifdef AUTO_REPEAT_EN
   localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;

   logic [1:0] w_held;

   // A direction only repeats while it alone is held and the cursor is free.
   assign w_held[BL] = ~w_deb[BL] & w_deb[BR] & r_arm[BL] & ~lock;
   assign w_held[BR] = ~w_deb[BR] & w_deb[BL] & r_arm[BR] & ~lock;

   for (genvar d = 0; d < 2; d++) begin : g_rep
      logic [RW-1:0] r_tmr;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_tmr <= '0;
         end else if (w_press[d] || !w_held[d]) begin
            r_tmr <= '0;
         end else if (r_tmr == RW'(REPEAT_CYCLES - 1)) begin
            r_tmr <= '0;
         end else begin
            r_tmr <= r_tmr + 1'b1;
         end
      end

      assign w_rep[d] = w_held[d] & ~w_press[d] & (r_tmr == RW'(REPEAT_CYCLES - 1));
   end
`else
   // No repeat logic: the expression is constant 0 for every legal period.
   assign w_rep = {2{REPEAT_CYCLES < 0}};
`endif

   // Confirm has priority over any move in the same cycle; opposing moves cancel.
   always_comb begin
      w_ok        = w_press[BK] & ~lock;
      w_step_l    = (w_press[BL] | w_rep[BL]) & ~lock;
      w_step_r    = (w_press[BR] | w_rep[BR]) & ~lock;
      w_mdc_nxt   = r_mdc;
      w_valid_nxt = 1'b0;
      if (w_ok) begin
         w_valid_nxt = 1'b1;
      end else if (w_step_r && !w_step_l) begin
         w_mdc_nxt = (r_mdc == LAST) ? 3'd0 : r_mdc + 3'd1;
      end else if (w_step_l && !w_step_r) begin
         w_mdc_nxt = (r_mdc == 3'd0) ? LAST : r_mdc - 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mdc     <= '0;
         r_col_sel <= 8'd1;
         r_valid   <= 1'b0;
      end else begin
         r_mdc     <= w_mdc_nxt;
         r_col_sel <= 8'd1 << w_mdc_nxt;
         r_valid   <= w_valid_nxt;
      end
   end

   assign mdc       = r_mdc;
   assign col_sel   = r_col_sel;
   assign col_valid = r_valid;

endmodule
